// File: rtl/exu_clmul_div_ctl_pkg.sv
// Shared types and helpers for the carry-less (GF(2)) polynomial divider.
package exu_clmul_div_ctl_pkg;

    localparam int XLEN  = 32;
    localparam int DEG_W = 5;
    localparam int CNT_W = 6;

    // Request packet as decode would hand it over.
    typedef struct packed {
        logic valid;
        logic rem;
    } clmul_div_pkt_t;

    // Index of the highest set coefficient; 0 for a zero polynomial.
    function automatic logic [DEG_W-1:0] poly_deg(input logic [XLEN-1:0] p);
        poly_deg = '0;
        for (int k = 0; k < XLEN; k++) begin
            if (p[k]) poly_deg = DEG_W'(k);
        end
    endfunction

    // Number of RUN cycles needed to retire quotient bits dg..31, k bits per cycle.
    function automatic logic [CNT_W-1:0] run_cycles(input logic [DEG_W-1:0] dg, input int k);
        run_cycles = CNT_W'((XLEN - int'(dg) + k - 1) / k);
    endfunction

endpackage

// File: rtl/exu_clmul_div_step.sv
// Combinational K-bit slice of GF(2) long division: retires quotient bits i, i-1, ... i-K+1.
module exu_clmul_div_step
    import exu_clmul_div_ctl_pkg::*;
#(
    parameter int K = 1
) (
    input  logic [XLEN-1:0]  r,
    input  logic [XLEN-1:0]  d,
    input  logic [DEG_W-1:0] dg,
    input  logic [CNT_W-1:0] i,
    input  logic [XLEN-1:0]  q,
    output logic [XLEN-1:0]  r_nxt,
    output logic [XLEN-1:0]  q_nxt
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        r_nxt = r;
        q_nxt = q;
        for (int j = 0; j < K; j++) begin
            idx = int'(i) - j;
            // Positions below deg(d) are no-ops; this absorbs the final partial group.
            if (idx >= int'(dg) && idx < XLEN && r_nxt[idx[DEG_W-1:0]]) begin
                r_nxt = r_nxt ^ (d << (idx - int'(dg)));
                q_nxt[DEG_W'(idx - int'(dg))] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exu_clmul_div_ctl.sv
// Iterative carry-less polynomial divider; returns quotient or remainder of a / b over GF(2).
module exu_clmul_div_ctl
    import exu_clmul_div_ctl_pkg::*;
#(
    parameter int K = 1
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            scan_mode,
    input  logic            valid,
    input  logic            rem,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            freeze,
    output logic            busy,
    output logic            finish,
    output logic [XLEN-1:0] out
);

    typedef enum logic [1:0] {IDLE, NORM, RUN, DONE} state_t;

    state_t          state, state_nxt;
    clmul_div_pkt_t  req;
    logic [XLEN-1:0] r_q, d_q, q_q;
    logic [XLEN-1:0] r_nxt, q_nxt;
    logic            rem_q;
    logic [DEG_W-1:0] dg_q;
    logic [CNT_W-1:0] i_q, cnt_q;
    logic            take, advance, data_en, d_zero;

    assign req     = '{valid: valid, rem: rem};
    assign take    = (state == IDLE) & req.valid & ~flush & ~freeze;
    assign advance = ~flush & ~freeze;
    assign d_zero  = (d_q == '0);
    // Mirrors the clock-header enable: data flops only move while a request is live.
    assign data_en = ((valid | busy) & ~freeze) | scan_mode;

    exu_clmul_div_step #(.K(K)) u_step (
        .r     (r_q),
        .d     (d_q),
        .dg    (dg_q),
        .i     (i_q),
        .q     (q_q),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    // NOTE: the state flop runs on the ungated clock so flush can always return it to IDLE.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (take) state_nxt = NORM;
            NORM: begin
                busy = 1'b1;
                if (advance) state_nxt = d_zero ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (advance && cnt_q == CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                finish = ~flush;
                if (advance) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_q   <= '0;
            d_q   <= '0;
            q_q   <= '0;
            rem_q <= 1'b0;
            dg_q  <= '0;
            i_q   <= '0;
            cnt_q <= '0;
            out   <= '0;
        end else if (data_en) begin
            case (state)
                IDLE: if (take) begin
                    r_q   <= a;
                    d_q   <= b;
                    rem_q <= req.rem;
                    q_q   <= '0;
                end
                NORM: if (advance) begin
                    dg_q  <= poly_deg(d_q);
                    i_q   <= CNT_W'(XLEN - 1);
                    cnt_q <= run_cycles(poly_deg(d_q), K);
                    if (d_zero) out <= rem_q ? r_q : q_q;
                end
                RUN: if (advance) begin
                    r_q   <= r_nxt;
                    q_q   <= q_nxt;
                    i_q   <= i_q - CNT_W'(K);
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) out <= rem_q ? r_nxt : q_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_clmul_div_ctl.sv
// Directed and random checks of the GF(2) divider against a long-division reference and a scoreboard.
module tb_exu_clmul_div_ctl;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        scan_mode = 1'b0;
    logic        valid1 = 1'b0, valid4 = 1'b0;
    logic        rem = 1'b0;
    logic        flush = 1'b0, freeze = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy1, finish1, busy4, finish4;
    logic [31:0] out1, out4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] out;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    exu_clmul_div_ctl #(.K(1)) dut1 (
        .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .valid(valid1), .rem(rem),
        .a(a), .b(b), .flush(flush), .freeze(freeze),
        .busy(busy1), .finish(finish1), .out(out1)
    );

    exu_clmul_div_ctl #(.K(4)) dut4 (
        .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .valid(valid4), .rem(rem),
        .a(a), .b(b), .flush(flush), .freeze(freeze),
        .busy(busy4), .finish(finish4), .out(out4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int deg_of(input logic [31:0] p);
        deg_of = -1;
        for (int k = 0; k < 32; k++) if (p[k]) deg_of = k;
    endfunction

    function automatic logic [63:0] clmul(input logic [31:0] x, input logic [31:0] y);
        clmul = '0;
        for (int k = 0; k < 32; k++) if (x[k]) clmul = clmul ^ ({32'b0, y} << k);
    endfunction

    function automatic void ref_div(input logic [31:0] ta, input logic [31:0] tbv,
                                    output logic [31:0] q, output logic [31:0] r);
        int db;
        q = '0;
        r = ta;
        if (tbv != '0) begin
            db = deg_of(tbv);
            for (int k = 31; k >= db; k--) begin
                if (r[k]) begin
                    r = r ^ (tbv << (k - db));
                    q[k - db] = 1'b1;
                end
            end
        end
    endfunction

    function automatic int ref_lat(input logic [31:0] tbv, input int k);
        ref_lat = (tbv == '0) ? 2 : 2 + (32 - deg_of(tbv) + k - 1) / k;
    endfunction

    // Issues one request in the current cycle (cycle 0) and waits for its finish pulse.
    task automatic do_op(input string tag, input bit use4, input logic [31:0] ta,
                         input logic [31:0] tbv, input logic tr, input int exp_lat,
                         input int freeze_at, output logic [31:0] got);
        exp_t        e;
        logic [31:0] rq, rr;
        int          cyc;
        bit          seen;
        ref_div(ta, tbv, rq, rr);
        e.out = tr ? rr : rq;
        e.lat = exp_lat;
        sb.push_back(e);
        a = ta; b = tbv; rem = tr;
        if (use4) valid4 = 1'b1; else valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0; valid4 = 1'b0;
        cyc = 1; seen = 1'b0; got = '0;
        while (cyc < 200 && !seen) begin
            if (freeze_at != 0 && cyc == freeze_at)     freeze = 1'b1;
            if (freeze_at != 0 && cyc == freeze_at + 5) freeze = 1'b0;
            @(negedge clk);
            if (use4 ? finish4 : finish1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        freeze = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            check({tag, "_timeout_cycles"}, 32'(cyc), 32'(e.lat));
        end else begin
            got = use4 ? out4 : out1;
            check({tag, "_out"}, got, e.out);
            check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
            check({tag, "_busy_at_finish"}, 32'(use4 ? busy4 : busy1), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gq, gr, ra, scratch;
        logic [63:0] prod;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy1), 32'd0);
        check("reset_finish", 32'(finish1), 32'd0);
        check("reset_out", out1, 32'd0);
        rst_l = 1'b1;
        @(posedge clk); #1;

        do_op("q_7_3", 1'b0, 32'h7, 32'h3, 1'b0, 33, 0, gq);
        do_op("r_7_3", 1'b0, 32'h7, 32'h3, 1'b1, 33, 0, gr);
        do_op("q_ones_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 34, 0, gq);
        do_op("r_ones_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1, 34, 0, gr);
        do_op("k4_q_ones_1", 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 10, 0, gq);
        do_op("q_div0", 1'b0, 32'h1234_5678, 32'h0, 1'b0, 2, 0, gq);
        do_op("r_div0", 1'b0, 32'h1234_5678, 32'h0, 1'b1, 2, 0, gr);
        do_op("q_aes_self", 1'b0, 32'h11B, 32'h11B, 1'b0, 26, 0, gq);
        do_op("r_aes_self", 1'b0, 32'h11B, 32'h11B, 1'b1, 26, 0, gr);

        for (int n = 0; n < 4; n++) begin
            ra = $urandom;
            do_op("rand_q", 1'b0, ra, 32'h11B, 1'b0, ref_lat(32'h11B, 1), 0, gq);
            do_op("rand_r", 1'b0, ra, 32'h11B, 1'b1, ref_lat(32'h11B, 1), 0, gr);
            prod = clmul(gq, 32'h11B);
            check("rand_identity", prod[31:0] ^ gr, ra);
            check("rand_rem_deg", gr >> 8, 32'd0);
        end
        ra = $urandom;
        do_op("k4_rand_r", 1'b1, ra, 32'h11B, 1'b1, ref_lat(32'h11B, 4), 0, gr);

        // Flush in cycle 10 of a long operation, then a new request in cycle 11.
        a = 32'hFFFF_FFFF; b = 32'h1; rem = 1'b0; valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check("flush_no_finish", 32'(finish1), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_next", 32'(busy1), 32'd0);
        do_op("after_flush", 1'b0, 32'h7, 32'h3, 1'b1, 33, 0, gr);

        // Flush coincident with valid: request dropped.
        a = 32'h7; b = 32'h3; valid1 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0; flush = 1'b0;
        check("flush_valid_busy", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        check("flush_valid_busy2", 32'(busy1), 32'd0);
        check("flush_valid_finish", 32'(finish1), 32'd0);

        // Five frozen cycles mid-RUN push finish out by exactly five cycles.
        do_op("freeze", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 39, 10, gq);

        // Asynchronous reset mid-RUN.
        a = 32'h1234_5678; b = 32'h11B; rem = 1'b1; valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_l = 1'b0;
        #1;
        check("areset_busy", 32'(busy1), 32'd0);
        check("areset_finish", 32'(finish1), 32'd0);
        check("areset_out", out1, 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk); #1;
        do_op("after_reset", 1'b0, 32'h1234_5678, 32'h11B, 1'b1, 26, 0, scratch);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exu_clmul_div_ctl.md
Name: exu_clmul_div_ctl

Overview:
- Iterative carry-less (GF(2)) polynomial divider; the inverse of the carry-less multiply/reduction path in the EXU multiplier.
- Takes dividend polynomial a and divisor polynomial b.
- Returns either quotient q or remainder r, with a ^ clmul(q,b) == r and deg(r) < deg(b).
- Sits beside the integer divider in the EXU, uses the same valid/flush/finish handshake, and writes back through the divide result mux.

Parameters:
- K, 1, quotient bits retired per RUN cycle; legal values 1, 2, 4.

Ports:
- clk  in  1  top-level clock
- rst_l  in  1  asynchronous active-low reset
- scan_mode  in  1  scan mode, passed to the clock headers
- valid  in  1  start request; accepted only when ~busy & ~flush
- rem  in  1  captured with valid; 1 = return remainder, 0 = return quotient
- a  in  32  dividend polynomial, bit i = coefficient of x^i
- b  in  32  divisor polynomial
- flush  in  1  kill any operation in flight
- freeze  in  1  pipeline freeze; holds all state
- busy  out  1  operation in progress (NORM or RUN state)
- finish  out  1  one-cycle pulse; out is valid in the same cycle
- out  out  32  result, registered

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_l).
- Reset values: state=IDLE; busy=0, finish=0, out=0; all internal registers 0.
- States:
  - IDLE: on valid & ~flush & ~freeze, capture a into r, b into d, rem into rem_q; clear q; go to NORM.
  - NORM: one cycle. Priority-encode deg(d) into dg (0..31).
    - If d==0 (divide by zero): q=0, r=a; go to DONE.
    - Otherwise: i=31; cnt=ceil((32-dg)/K); go to RUN.
  - RUN: each cycle, for each of K sub-steps, with i running downward and stopping at i<dg:
    - if r[i]: r ^= d<<(i-dg) and q[i-dg]=1.
    - i decrements by K per cycle; cnt decrements by 1.
    - When cnt reaches 1 this cycle, go to DONE.
    - Sub-steps past i<dg are no-ops; this covers the last partial group when (32-dg) is not a multiple of K.
  - DONE: finish=1 for exactly one cycle; out = rem_q ? r : q; next state IDLE.
    - out holds its value after finish until the next finish or reset.
- Latency: with valid in cycle 0, finish arrives in cycle 2+ceil((32-dg)/K), or cycle 2 when b==0. Worst case (K=1, b=1) is cycle 34.
- busy=1 in NORM and RUN, and 0 in DONE, so a new valid may be accepted in the cycle after finish.
- valid while busy: ignored; decode guarantees this never happens.
- flush, any state: next state IDLE, no finish; flush in DONE suppresses finish.
- flush in the same cycle as valid: flush wins; the request is not accepted.
- freeze: all state, counters and outputs hold. finish stays asserted while frozen in DONE, and is counted once when freeze drops.
- flush and freeze together: flush wins.
- Async reset mid-operation: immediate return to IDLE with all outputs 0.
- Degenerate operands need no special path:
  - deg(a) < deg(b) naturally yields q=0, r=a.
  - a==0 yields q=0, r=0.
- Gating: clock headers gate data flops on (valid|busy) & ~freeze. The state flop uses the ungated clock.

Decomposition:
- Shared package (swerv_types): add clmul_div_pkt_t {valid, rem}. Decode drives it as an input struct in place of separate valid/rem if preferred.
- State encoding constants live in the module as a local enum.
- One sub-module: exu_clmul_div_step.
  - Combinational K-step reduction slice.
  - Inputs: r, d, dg, i, q. Outputs: next r, next q.
  - Instantiated once and unrolled by K.

Test Plan:
- a=0x7, b=0x3, rem=0/1, K=1 -> dg=1; finish in cycle 33; out=0x2 (quotient) and 0x1 (remainder) respectively.
- a=0xFFFF_FFFF, b=0x1, rem=0 -> finish in cycle 34, out=0xFFFF_FFFF. With rem=1 -> out=0x0. With K=4 -> finish in cycle 10.
- a=0x1234_5678, b=0 -> finish in cycle 2; rem=0 gives out=0, rem=1 gives out=0x1234_5678.
- a=0x11B, b=0x11B (AES polynomial) -> q=0x1, r=0. Random a with b=0x11B checked against the reference model: a==clmul(q,b)^r and deg(r)<8.
- flush in cycle 10 of a running op -> no finish; busy=0 in cycle 11; new valid in cycle 11 accepted and completes correctly. flush coincident with valid -> busy stays 0.
- freeze for 5 cycles mid-RUN -> finish delayed by exactly 5 cycles, same out. Assert rst_l low mid-RUN -> busy/finish/out=0 immediately; next op correct.
